// File: rtl/decoder38_seq.sv
// decoder38_seq: buffered 3-to-8 decoder that replays each code as a
// registered one-hot pulse of PULSE_LEN cycles followed by GAP_LEN zero cycles.
module decoder38_seq #(
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    output logic       i_ready,
    input  logic [2:0] i,
    input  logic       en,
    output logic [7:0] y,
    output logic       y_valid,
    output logic       busy,
    output logic [7:0] dec_count
);

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_LEN - 1);
    localparam logic [3:0] GAP_LOAD   = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;
    localparam bit         HAS_GAP    = (GAP_LEN > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [7:0]  y_d;
    logic [7:0]  dcnt_d;

    logic [2:0]  mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  level;
    logic        full, empty, push, pop;
    logic [7:0]  onehot;

    assign full    = (level == 2'd2);
    assign empty   = (level == 2'd0);
    assign i_ready = !full;
    assign push    = i_valid && !full;
    assign onehot  = 8'd1 << mem[rd_ptr];
    assign busy    = (state != IDLE) || !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            level  <= 2'd0;
            mem[0] <= 3'd0;
            mem[1] <= 3'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= i;
                wr_ptr      <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            // Simultaneous push and pop leaves the level unchanged
            if (push && !pop)
                level <= level + 2'd1;
            else if (pop && !push)
                level <= level - 2'd1;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        y_d     = y;
        dcnt_d  = dec_count;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                y_d = 8'd0;
                if (!empty && en) begin
                    pop     = 1'b1;
                    y_d     = onehot;
                    cnt_d   = PULSE_LOAD;
                    dcnt_d  = dec_count + 8'd1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else if (HAS_GAP) begin
                    y_d     = 8'd0;
                    cnt_d   = GAP_LOAD;
                    state_d = GAP;
                end else if (!empty && en) begin
                    pop    = 1'b1;
                    y_d    = onehot;
                    cnt_d  = PULSE_LOAD;
                    dcnt_d = dec_count + 8'd1;
                end else begin
                    y_d     = 8'd0;
                    state_d = IDLE;
                end
            end
            GAP: begin
                y_d = 8'd0;
                if (cnt != 4'd0)
                    cnt_d = cnt - 4'd1;
                else
                    state_d = IDLE;
            end
            default: begin
                y_d     = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            y         <= 8'd0;
            y_valid   <= 1'b0;
            dec_count <= 8'd0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            y         <= y_d;
            y_valid   <= (y_d != 8'd0);
            dec_count <= dcnt_d;
        end
    end

endmodule

// File: tb/tb_decoder38_seq.sv
// tb_decoder38_seq: directed-vector bench for decoder38_seq, default and
// back-to-back (PULSE_LEN=1, GAP_LEN=0) configurations.
module tb_decoder38_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid, en;
    logic [2:0] i;
    logic       i_ready, y_valid, busy;
    logic [7:0] y, dec_count;

    logic       i_valid0, en0;
    logic [2:0] i0;
    logic       i_ready0, y_valid0, busy0;
    logic [7:0] y0, dec_count0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decoder38_seq dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_ready(i_ready), .i(i), .en(en),
        .y(y), .y_valid(y_valid), .busy(busy), .dec_count(dec_count)
    );

    decoder38_seq #(.PULSE_LEN(1), .GAP_LEN(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid0), .i_ready(i_ready0), .i(i0), .en(en0),
        .y(y0), .y_valid(y_valid0), .busy(busy0), .dec_count(dec_count0)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [2:0] code);
        logic acc;
        acc     = 1'b0;
        i       = code;
        i_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            acc = i_ready;
            tick();
            if (acc) break;
        end
        i_valid = 1'b0;
        if (!acc) check("push_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int n = 0; n < limit; n++) begin
            if (!busy) break;
            tick();
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    logic [7:0] run_val [16];
    int         run_len [16];
    int         nruns;
    logic       saw_full;
    int         bad_hot;

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i = 3'd0; en = 1'b0;
        i_valid0 = 1'b0; i0 = 3'd0; en0 = 1'b0;
        #12;
        check("rst_y", {24'd0, y}, 32'd0);
        check("rst_yv", {31'd0, y_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cnt", {24'd0, dec_count}, 32'd0);
        check("rst_ready", {31'd0, i_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // single code 3, default timing
        en = 1'b1; i = 3'd3; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("t1_e0_y", {24'd0, y}, 32'h00);
        tick();
        check("t1_e1_y", {24'd0, y}, 32'h08);
        check("t1_e1_yv", {31'd0, y_valid}, 32'd1);
        tick();
        check("t1_e2_y", {24'd0, y}, 32'h08);
        tick();
        check("t1_e3_y", {24'd0, y}, 32'h00);
        check("t1_e3_yv", {31'd0, y_valid}, 32'd0);
        check("t1_e3_busy", {31'd0, busy}, 32'd1);
        tick();
        check("t1_e4_busy", {31'd0, busy}, 32'd0);
        check("t1_cnt", {24'd0, dec_count}, 32'd1);

        // stream 0..7
        do_reset();
        en = 1'b1; nruns = 0; saw_full = 1'b0; bad_hot = 0;
        fork
            begin
                for (int c = 0; c < 8; c++) push(3'(c));
            end
            begin
                logic [7:0] prev;
                prev = 8'd0;
                for (int cyc = 0; cyc < 60; cyc++) begin
                    tick();
                    if (!i_ready) saw_full = 1'b1;
                    if ($countones(y) > 1) bad_hot++;
                    if (y != 8'd0) begin
                        if (y == prev) run_len[nruns-1]++;
                        else if (nruns < 16) begin
                            run_val[nruns] = y;
                            run_len[nruns] = 1;
                            nruns++;
                        end
                    end
                    prev = y;
                end
            end
        join
        check("t2_nruns", nruns, 8);
        for (int k = 0; k < 8 && k < nruns; k++) begin
            check($sformatf("t2_val%0d", k), {24'd0, run_val[k]}, 32'd1 << k);
            check($sformatf("t2_len%0d", k), run_len[k], 2);
        end
        check("t2_full_seen", {31'd0, saw_full}, 32'd1);
        check("t2_onehot", bad_hot, 0);
        check("t2_cnt", {24'd0, dec_count}, 32'd8);
        wait_idle("t2_idle", 20);

        // back-to-back with zero gap
        do_reset();
        en0 = 1'b0; i0 = 3'd5; i_valid0 = 1'b1;
        tick();
        i0 = 3'd2;
        tick();
        i_valid0 = 1'b0;
        check("t3_ready", {31'd0, i_ready0}, 32'd0);
        check("t3_busy", {31'd0, busy0}, 32'd1);
        check("t3_y_pre", {24'd0, y0}, 32'h00);
        en0 = 1'b1;
        tick();
        check("t3_y_a", {24'd0, y0}, 32'h20);
        tick();
        check("t3_y_b", {24'd0, y0}, 32'h04);
        tick();
        check("t3_y_c", {24'd0, y0}, 32'h00);
        check("t3_cnt", {24'd0, dec_count0}, 32'd2);

        // en gating, pulse not truncated
        do_reset();
        en = 1'b0;
        push(3'd6);
        push(3'd1);
        check("t4_ready", {31'd0, i_ready}, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd1);
        tick(); tick();
        check("t4_y_hold", {24'd0, y}, 32'h00);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("t4_y_a", {24'd0, y}, 32'h40);
        tick();
        check("t4_y_b", {24'd0, y}, 32'h40);
        tick();
        check("t4_y_gap", {24'd0, y}, 32'h00);
        tick(); tick(); tick();
        check("t4_y_stop", {24'd0, y}, 32'h00);
        check("t4_busy2", {31'd0, busy}, 32'd1);
        check("t4_cnt", {24'd0, dec_count}, 32'd1);

        // async reset mid-pulse
        en = 1'b1;
        wait_idle("t5_drain", 20);
        push(3'd4);
        tick();
        check("t5_y_on", {24'd0, y}, 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_y_rst", {24'd0, y}, 32'h00);
        check("t5_yv_rst", {31'd0, y_valid}, 32'd0);
        check("t5_cnt_rst", {24'd0, dec_count}, 32'd0);
        check("t5_ready_rst", {31'd0, i_ready}, 32'd1);
        check("t5_busy_rst", {31'd0, busy}, 32'd0);
        #1;
        rst_n = 1'b1;
        i = 3'd7; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("t5_y_push", {24'd0, y}, 32'h00);
        tick();
        check("t5_y_7", {24'd0, y}, 32'h80);
        wait_idle("t5_idle", 20);

        // dec_count wrap
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 256; k++) push(3'd1);
        wait_idle("t6_idle", 40);
        check("t6_wrap", {24'd0, dec_count}, 32'd0);
        push(3'd1);
        wait_idle("t6_idle2", 40);
        check("t6_after", {24'd0, dec_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
